// File: rtl/buffer_read_arbiter_if.sv
// Bundle between the read-buffer controllers, the shared input buffer and the arbiter.
// master: arbiter side. slave: requester/buffer side.
interface buffer_read_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 8
);
  logic [NUM_REQ-1:0] req;
  logic               buf_valid;
  logic [CNT_W-1:0]   burst_len;
  logic               buf_read_req;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] valid_out;
  logic               busy;
  logic [CNT_W-1:0]   beat_cnt;

  modport master (
    input  req, buf_valid, burst_len,
    output buf_read_req, grant, valid_out, busy, beat_cnt
  );

  modport slave (
    output req, buf_valid, burst_len,
    input  buf_read_req, grant, valid_out, busy, beat_cnt
  );
endinterface

// File: rtl/buffer_read_arbiter.sv
// Shares one input buffer among NUM_REQ read-buffer controllers, granting bursts of beats.
// Define ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module buffer_read_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 8
) (
  input logic                   clk,
  input logic                   rst,
  input logic                   inner_rst,
  buffer_read_arbiter_if.master bus
);
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [IdxW-1:0]    last_q, last_d;

  logic [NUM_REQ-1:0] winner;
  logic [IdxW-1:0]    grant_idx;
  logic               req_g;
  logic               burst_done;

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req[i]) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end
`else
  // Search starts one past the most recently granted lane and wraps.
  always_comb begin
    logic            found;
    logic [IdxW-1:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IdxW'((32'(last_q) + i) % NUM_REQ);
      if (!found && bus.req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) grant_idx = IdxW'(i);
    end
  end

  assign req_g      = |(bus.req & grant_q);
  assign burst_done = (bus.burst_len != '0) && (beat_cnt_q == bus.burst_len);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      last_q     <= IdxW'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    last_d     = last_q;
    if (inner_rst) begin
      state_d    = StIdle;
      grant_d    = '0;
      beat_cnt_d = '0;
      last_d     = IdxW'(NUM_REQ - 1);
    end else begin
      case (state_q)
        StIdle: begin
          if (|bus.req) begin
            state_d    = StGrant;
            grant_d    = winner;
            beat_cnt_d = '0;
          end
        end
        StGrant: begin
          if (!req_g) begin
            state_d = StIdle;
            grant_d = '0;
            last_d  = grant_idx;
          end else if (bus.buf_valid) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            state_d    = StGap;
          end
        end
        StGap: begin
          if (burst_done) begin
            state_d = StIdle;
            grant_d = '0;
            last_d  = grant_idx;
          end else begin
            state_d = StGrant;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    bus.buf_read_req = 1'b0;
    bus.valid_out    = '0;
    if (state_q == StGrant) begin
      bus.buf_read_req = req_g;
      bus.valid_out    = grant_q & bus.req & {NUM_REQ{bus.buf_valid}};
    end
  end

  assign bus.grant    = grant_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.beat_cnt = beat_cnt_q;
endmodule

// File: tb/tb_buffer_read_arbiter.sv
// Directed vector table plus hand-written sequences for buffer_read_arbiter.
module tb_buffer_read_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned CNT_W   = 8;

`ifdef ARB_FIXED_PRIORITY_EN
  localparam logic [3:0] G1 = 4'b0001;
  localparam logic [3:0] G2 = 4'b0001;
  localparam logic [3:0] G3 = 4'b0001;
`else
  localparam logic [3:0] G1 = 4'b0010;
  localparam logic [3:0] G2 = 4'b0100;
  localparam logic [3:0] G3 = 4'b1000;
`endif

  typedef struct packed {
    logic [3:0] req;
    logic       bv;
    logic [7:0] bl;
    logic       irst;
    logic [3:0] g;
    logic       brr;
    logic [3:0] vo;
    logic       busy;
    logic [7:0] beat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic inner_rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  buffer_read_arbiter_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

  buffer_read_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .inner_rst(inner_rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic bv, input logic [7:0] bl, input logic ir,
                     input logic [3:0] g, input logic brr, input logic [3:0] vo,
                     input logic bsy, input logic [7:0] bt);
    vec_t v;
    v = '{req: r, bv: bv, bl: bl, irst: ir, g: g, brr: brr, vo: vo, busy: bsy, beat: bt};
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before sampling.
  task automatic step(input logic [3:0] r, input logic bv, input logic [7:0] bl);
    @(negedge clk);
    bus.req       = r;
    bus.buf_valid = bv;
    bus.burst_len = bl;
    inner_rst     = 1'b0;
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_beat;

    rst           = 1'b0;
    inner_rst     = 1'b0;
    bus.req       = '0;
    bus.buf_valid = 1'b0;
    bus.burst_len = '0;
    #2;
    check("reset grant", 32'(bus.grant), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset beat_cnt", 32'(bus.beat_cnt), 32'd0);
    check("reset buf_read_req", 32'(bus.buf_read_req), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    //  req      bv    bl    irst  grant    brr   vout     busy  beat
    // basic burst of two beats
    add(4'b0001, 1'b0, 8'd2, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd0);
    add(4'b0001, 1'b1, 8'd2, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'd0);
    add(4'b0001, 1'b0, 8'd2, 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 8'd1);
    add(4'b0001, 1'b1, 8'd2, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'd1);
    add(4'b0001, 1'b1, 8'd2, 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 8'd2);
    add(4'b0000, 1'b1, 8'd2, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd2);
    // inner_rst beats arbitration, then full contention with burst_len=1
    add(4'b1111, 1'b0, 8'd1, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd2);
    add(4'b1111, 1'b0, 8'd1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd0);
    add(4'b1111, 1'b1, 8'd1, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'd0);
    add(4'b1111, 1'b0, 8'd1, 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 8'd1);
    add(4'b1111, 1'b0, 8'd1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd1);
    add(4'b1111, 1'b1, 8'd1, 1'b0, G1,      1'b1, G1,      1'b1, 8'd0);
    add(4'b1111, 1'b0, 8'd1, 1'b0, G1,      1'b0, 4'b0000, 1'b1, 8'd1);
    add(4'b1111, 1'b0, 8'd1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd1);
    add(4'b1111, 1'b1, 8'd1, 1'b0, G2,      1'b1, G2,      1'b1, 8'd0);
    add(4'b1111, 1'b0, 8'd1, 1'b0, G2,      1'b0, 4'b0000, 1'b1, 8'd1);
    add(4'b1111, 1'b0, 8'd1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd1);
    add(4'b1111, 1'b1, 8'd1, 1'b0, G3,      1'b1, G3,      1'b1, 8'd0);
    add(4'b1111, 1'b0, 8'd1, 1'b0, G3,      1'b0, 4'b0000, 1'b1, 8'd1);
    add(4'b1111, 1'b0, 8'd1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd1);
    add(4'b1111, 1'b1, 8'd1, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'd0);
    add(4'b1111, 1'b0, 8'd1, 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 8'd1);
    // early drop of lane 2, then 0110 resumes search at lane 3
    add(4'b0100, 1'b0, 8'd1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd1);
    add(4'b0100, 1'b0, 8'd1, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b1, 8'd0);
    add(4'b0000, 1'b1, 8'd1, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 8'd0);
    add(4'b0110, 1'b0, 8'd1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd0);
    add(4'b0110, 1'b1, 8'd1, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'd0);
    add(4'b0000, 1'b0, 8'd1, 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'd1);
    add(4'b0000, 1'b0, 8'd1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd1);
    // inner_rst mid-burst
    add(4'b0001, 1'b0, 8'd3, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd1);
    add(4'b0001, 1'b1, 8'd3, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'd0);
    add(4'b0001, 1'b0, 8'd3, 1'b1, 4'b0001, 1'b0, 4'b0000, 1'b1, 8'd1);
    add(4'b0000, 1'b0, 8'd3, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.req       = vecs[i].req;
      bus.buf_valid = vecs[i].bv;
      bus.burst_len = vecs[i].bl;
      inner_rst     = vecs[i].irst;
      #2;
      check($sformatf("row%0d grant", i), 32'(bus.grant), 32'(vecs[i].g));
      check($sformatf("row%0d buf_read_req", i), 32'(bus.buf_read_req), 32'(vecs[i].brr));
      check($sformatf("row%0d valid_out", i), 32'(bus.valid_out), 32'(vecs[i].vo));
      check($sformatf("row%0d busy", i), 32'(bus.busy), 32'(vecs[i].busy));
      check($sformatf("row%0d beat_cnt", i), 32'(bus.beat_cnt), 32'(vecs[i].beat));
    end

    // Unlimited burst: 300 beats on lane 1, counter wraps, grant never released.
    step(4'b0010, 1'b0, 8'd0);
    check("unl idle busy", 32'(bus.busy), 32'd0);
    exp_beat = 8'd0;
    for (int k = 0; k < 300; k++) begin
      step(4'b0010, 1'b1, 8'd0);
      check("unl grant", 32'(bus.grant), 32'b0010);
      check("unl valid_out beat", 32'(bus.valid_out), 32'b0010);
      check("unl beat_cnt", 32'(bus.beat_cnt), 32'(exp_beat));
      exp_beat = exp_beat + 8'd1;
      step(4'b0010, 1'b1, 8'd0);
      check("unl gap valid_out", 32'(bus.valid_out), 32'd0);
      check("unl gap buf_read_req", 32'(bus.buf_read_req), 32'd0);
      check("unl gap grant", 32'(bus.grant), 32'b0010);
    end
    check("unl final beat_cnt", 32'(bus.beat_cnt), 32'd44);
    step(4'b0000, 1'b0, 8'd0);
    check("unl drop buf_read_req", 32'(bus.buf_read_req), 32'd0);
    check("unl drop busy", 32'(bus.busy), 32'd1);
    step(4'b0000, 1'b0, 8'd0);
    check("unl release busy", 32'(bus.busy), 32'd0);
    check("unl release grant", 32'(bus.grant), 32'd0);

    // Asynchronous reset in GAP mid-burst, then 1001 grants lane 0.
    step(4'b0001, 1'b0, 8'd4);
    step(4'b0001, 1'b1, 8'd4);
    check("rst pre grant", 32'(bus.grant), 32'b0001);
    step(4'b0001, 1'b0, 8'd4);
    check("rst gap busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    check("rst async grant", 32'(bus.grant), 32'd0);
    check("rst async busy", 32'(bus.busy), 32'd0);
    check("rst async buf_read_req", 32'(bus.buf_read_req), 32'd0);
    check("rst async beat_cnt", 32'(bus.beat_cnt), 32'd0);
    @(negedge clk);
    rst     = 1'b1;
    bus.req = 4'b1001;
    #2;
    check("rst release grant", 32'(bus.grant), 32'd0);
    step(4'b1001, 1'b0, 8'd4);
    check("rst regrant grant", 32'(bus.grant), 32'b0001);
    check("rst regrant buf_read_req", 32'(bus.buf_read_req), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
